spi_controller_tx: RTL
======================

Name: spi_controller_tx

Overview:
- SPI Mode 0 controller (initiator) that serialises one 16-bit register-write frame per request onto sclk/copi/ncs.
- Used by test harnesses and on-chip configuration logic to program the design's SPI peripheral register file (PWM enable/duty registers).
- Write-only; no CIPO path.
- Frame, MSB first: bit15 = 1 (write), bits14:8 = address, bits7:0 = data.

Parameters:
- CLK_DIV, 4: clk cycles per sclk half-period; legal range ≥2.
- CS_SETUP, 2: clk cycles from ncs falling to the first sclk rising-phase start; legal range ≥1.
- CS_HOLD, 2: clk cycles from the last sclk falling edge to ncs rising; legal range ≥1.
- CS_IDLE, 16: minimum clk cycles ncs stays high before the next frame; legal range ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request strobe.
- req_ready  out  1  controller can accept a request.
- req_addr  in  7  register address.
- req_data  in  8  register data.
- busy  out  1  frame in progress, including the CS_IDLE gap.
- done  out  1  one-cycle pulse at frame completion.
- sclk  out  1  SPI clock; idles low.
- copi  out  1  serial data, MSB first.
- ncs  out  1  chip select, active low.

Behaviour:
- Reset:
  - All outputs are registered; no combinational paths from inputs to outputs.
  - While rst_n = 0: sclk=0, copi=0, ncs=1, busy=0, done=0, req_ready=1, state=IDLE, all counters cleared.
  - Reset takes effect asynchronously, including mid-frame (ncs rises immediately).
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE:
  - req_ready=1, busy=0.
  - On a clk edge with req_valid & req_ready: latch shreg={1'b1, req_addr, req_data}.
  - In the same edge: ncs←0, copi←bit15, busy←1, req_ready←0; go to SETUP.
  - Requests are captured once; later input changes have no effect on the frame.
- SETUP:
  - Hold ncs=0, sclk=0 for CS_SETUP cycles, counting from ncs falling, then go to SHIFT.
- SHIFT, 16 bits:
  - Each bit is CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1.
  - sclk rises at the low→high transition; the peripheral samples copi there.
  - At each sclk fall, shift shreg left and drive the next bit on copi.
  - copi is stable for the full high phase and for ≥CLK_DIV cycles before each rising edge.
  - 5-bit bit counter: after the 16th high phase, sclk←0 and go to HOLD. Do not drive a 17th bit.
- HOLD:
  - ncs=0, sclk=0, copi=0 for CS_HOLD cycles.
  - Then ncs←1, done←1 for exactly one cycle; go to GAP.
- GAP:
  - ncs=1, busy=1, req_ready=0 for CS_IDLE cycles; then IDLE with busy←0, req_ready←1.
  - req_valid is ignored here.
- Timing:
  - ncs low duration is exactly CS_SETUP + 32·CLK_DIV + CS_HOLD cycles (132 with defaults).
  - Accept-to-next-accept is at least 1 + that + CS_IDLE (149 with defaults).
- Exactly 16 sclk rising edges per frame.
  - sclk never toggles while ncs=1.
  - ncs never changes while sclk=1.
- Back-to-back requests:
  - req_valid held high is accepted on the first IDLE cycle after GAP.
  - No request is queued during busy.
- Counters: the half-period counter is clog2(CLK_DIV)+1 bits; it wraps to 0 at each phase end. No other wrap-around.

Test Plan:
1. Defaults; request addr=0x00, data=0xA5.
   - Sample copi on each sclk rise; required: 16 edges forming 0x80A5.
   - ncs low exactly 132 cycles; done high one cycle, coincident with ncs rising.
2. req_valid held high with addr=0x01/data=0x3C, then addr=0x02/data=0xC3.
   - Required: two frames 0x813C then 0x82C3.
   - ncs high ≥16 cycles between them; req_ready low throughout each frame plus gap.
3. Change req_addr/req_data every cycle while busy.
   - Required: transmitted frame equals the values at the accept edge only.
   - No extra accepts while req_ready=0.
4. Assert rst_n=0 asynchronously just after the 8th sclk rise.
   - Required: same-instant ncs=1, sclk=0, busy=0.
   - After release, a new request (addr=0x04, data=0xFF) sends a clean 0x84FF.
5. CLK_DIV=2, CS_SETUP=1, CS_HOLD=1.
   - Required: sclk period exactly 4 clk; ncs low exactly 66 cycles; frame bits correct.
6. End-to-end with the design's SPI peripheral as the load.
   - Write addr=0x00 data=0xFF, then addr=0x04 data=0x80.
   - Required: the peripheral's outputs reflect each frame after its post-ncs processing delay, with no missed or extra bits.

Source files
------------

// File: rtl/spi_controller_tx.sv
// SPI mode 0 write-only initiator. Each accepted request is sent as one
// 16-bit frame, MSB first: {1'b1 (write), addr[6:0], data[7:0]}.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   req_valid  request strobe; accepted when req_ready is high
//   req_ready  controller idle and able to take a request
//   req_addr   7-bit register address, captured at accept
//   req_data   8-bit register data, captured at accept
//   busy       frame in progress, including the inter-frame gap
//   done       one-cycle pulse coincident with ncs rising
//   sclk       SPI clock, idles low
//   copi       serial data out
//   ncs        chip select, active low
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ncs high, waiting for a request
// SETUP | ncs low, sclk low for CS_SETUP cycles before the first bit
// SHIFT | 16 bits, each CLK_DIV cycles sclk low then CLK_DIV cycles high
// HOLD  | ncs low, sclk low for CS_HOLD cycles after the last fall
// GAP   | ncs high for CS_IDLE cycles, requests ignored
module spi_controller_tx #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       copi,
    output logic       ncs
);

    localparam int HW   = $clog2(CLK_DIV) + 1;
    localparam int TMAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE)
                                               : ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [HW-1:0] HLAST   = HW'(CLK_DIV - 1);
    localparam logic [TW-1:0] T_SETUP = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0] T_HOLD  = TW'(CS_HOLD - 1);
    localparam logic [TW-1:0] T_IDLE  = TW'(CS_IDLE - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t         state, state_n;
    logic [HW-1:0]  hcnt, hcnt_n;
    logic [4:0]     bcnt, bcnt_n;
    logic [TW-1:0]  tmr, tmr_n;
    // Bits still to send after the one on copi; bit 15 (write flag) goes
    // straight to copi at accept so it is never stored here.
    logic [14:0]    shreg, shreg_n;
    logic           sclk_n, copi_n, ncs_n, busy_n, done_n, req_ready_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hcnt      <= '0;
            bcnt      <= '0;
            tmr       <= '0;
            shreg     <= '0;
            sclk      <= 1'b0;
            copi      <= 1'b0;
            ncs       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state     <= state_n;
            hcnt      <= hcnt_n;
            bcnt      <= bcnt_n;
            tmr       <= tmr_n;
            shreg     <= shreg_n;
            sclk      <= sclk_n;
            copi      <= copi_n;
            ncs       <= ncs_n;
            busy      <= busy_n;
            done      <= done_n;
            req_ready <= req_ready_n;
        end
    end

    always_comb begin
        state_n     = state;
        hcnt_n      = hcnt;
        bcnt_n      = bcnt;
        tmr_n       = tmr;
        shreg_n     = shreg;
        sclk_n      = sclk;
        copi_n      = copi;
        ncs_n       = ncs;
        busy_n      = busy;
        done_n      = 1'b0;
        req_ready_n = req_ready;

        case (state)
            IDLE: begin
                busy_n      = 1'b0;
                req_ready_n = 1'b1;
                if (req_valid && req_ready) begin
                    shreg_n     = {req_addr, req_data};
                    copi_n      = 1'b1;
                    ncs_n       = 1'b0;
                    busy_n      = 1'b1;
                    req_ready_n = 1'b0;
                    tmr_n       = T_SETUP;
                    state_n     = SETUP;
                end
            end
            SETUP: begin
                if (tmr == '0) begin
                    hcnt_n  = '0;
                    bcnt_n  = '0;
                    state_n = SHIFT;
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            SHIFT: begin
                if (hcnt == HLAST) begin
                    hcnt_n = '0;
                    if (!sclk) begin
                        sclk_n = 1'b1;
                    end else begin
                        sclk_n = 1'b0;
                        if (bcnt == 5'd15) begin
                            // Last high phase ended: no 17th bit, park copi low.
                            copi_n  = 1'b0;
                            bcnt_n  = '0;
                            tmr_n   = T_HOLD;
                            state_n = HOLD;
                        end else begin
                            copi_n  = shreg[14];
                            shreg_n = {shreg[13:0], 1'b0};
                            bcnt_n  = bcnt + 5'd1;
                        end
                    end
                end else begin
                    hcnt_n = hcnt + 1'b1;
                end
            end
            HOLD: begin
                if (tmr == '0) begin
                    ncs_n   = 1'b1;
                    done_n  = 1'b1;
                    tmr_n   = T_IDLE;
                    state_n = GAP;
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            GAP: begin
                if (tmr == '0) begin
                    busy_n      = 1'b0;
                    req_ready_n = 1'b1;
                    state_n     = IDLE;
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
